regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_W, 64, write-back data width; ADDR_W, 5, register address width; NREG, 32, register count.
REQ-002 Ports (name, direction, width, meaning) SHALL be, with clock and reset first:
  - clk  in  1  single clock, rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
REQ-003 Issue-side ports SHALL be:
  - iss_valid  in  1  instruction issue attempt.
  - iss_ra  in  ADDR_W  source A address.
  - iss_rb  in  ADDR_W  source B address.
  - iss_rd  in  ADDR_W  destination address.
  - iss_wr  in  1  instruction writes rd.
  - iss_stall  out  1  hazard; issue not accepted.
REQ-004 ALU write-back ports SHALL be:
  - alu_valid  in  1  request.
  - alu_rd  in  ADDR_W  destination.
  - alu_data  in  DATA_W  result.
  - alu_ready  out  1  grant.
REQ-005 Memory/NIC write-back ports SHALL be mem_valid, mem_rd, mem_data and mem_ready, with the same widths and meanings as REQ-004.
REQ-006 Register-file write-port ports SHALL be:
  - rf_we  out  1  write enable.
  - rf_waddr  out  ADDR_W  write address.
  - rf_wdata  out  DATA_W  write data.
REQ-007 Vectors SHALL use MSB-at-index-0 ordering, consistent with the register file.

Function
REQ-008 The block SHALL keep a busy scoreboard of NREG bits, one per register; bit 0 SHALL be hardwired to 0.
REQ-009 iss_stall SHALL be combinational and SHALL be 1 when iss_valid=1 and any of the following holds:
  - busy[iss_ra]=1;
  - busy[iss_rb]=1;
  - iss_wr=1 and busy[iss_rd]=1 (WAW hazard).
REQ-010 An issue is accepted when iss_valid=1 and iss_stall=0; an accepted issue with iss_wr=1 and iss_rd!=0 SHALL set busy[iss_rd] at the next clock edge.
REQ-011 Arbitration SHALL be two-way round-robin with a 1-bit pointer prio (0=ALU, 1=MEM):
  - one requester valid: that requester is granted;
  - both valid: the requester named by prio is granted;
  - after each grant, prio SHALL point to the non-granted requester.
REQ-012 alu_ready and mem_ready SHALL be combinational grant signals; at most one SHALL be 1 in any cycle; a request transfers when valid and ready are both 1.
REQ-013 A requester SHALL hold valid, rd and data stable until it is granted; the block SHALL NOT buffer more than one grant per cycle.
REQ-014 A granted transfer SHALL appear as registered outputs one cycle later:
  - rf_we=1, with rf_waddr and rf_wdata equal to the granted rd and data;
  - rf_we=0 in cycles with no grant.
REQ-015 A transfer with rd=0 SHALL still be granted, but SHALL drive rf_we=0 for that transfer.
REQ-016 busy[rd] SHALL clear at the same clock edge that registers the grant, so a dependent issue may proceed in the cycle rf_we is high.
REQ-017 If a clear and a set of the same register occur at the same edge, the set SHALL win and busy SHALL remain 1.
REQ-018 rf_waddr and rf_wdata SHALL hold their last values when rf_we=0.

Reset
REQ-019 reset_n=0 SHALL immediately clear:
  - busy to all 0;
  - prio to 0;
  - rf_we, rf_waddr and rf_wdata to 0.
REQ-020 During reset, alu_ready, mem_ready and iss_stall SHALL be 0.
REQ-021 Any in-flight write-back SHALL be dropped on reset, with no rf_we pulse after deassertion.
REQ-022 Operation SHALL resume on the first rising clk edge after reset_n returns to 1.

Structure
REQ-023 A shared package SHALL hold DATA_W, ADDR_W and NREG defaults, plus the localparams PRIO_ALU=0 and PRIO_MEM=1.
REQ-024 The round-robin arbiter SHALL be a sub-module named rr_arbiter2 (inputs req[0:1], advance; output gnt[0:1]; holds the prio flop).
REQ-025 The scoreboard and write-port register SHALL reside in regfile_wb_scheduler.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Issue rd=5 (busy[5]=1), then issue ra=5 -> iss_stall=1. Grant ALU rd=5 with data 0xDEAD -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEAD, and the issue proceeds that cycle.
  - ALU and MEM both valid for 4 cycles, with data held -> grants alternate ALU, MEM, ALU, MEM from reset prio=0.
  - Issue rd=7 at the same edge as a grant to rd=7 -> busy[7]=1 afterwards.
  - MEM write-back rd=0 -> mem_ready=1, rf_we=0 the next cycle; iss_rd=0 never stalls.
  - Assert reset_n=0 while a grant is registered -> rf_we=0 immediately, busy all 0, and no rf_we after release.
  - Issue rd=3 while busy[3]=1 -> iss_stall=1 (WAW) until the write-back to 3 is granted.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// ============================================================================
// Module : regfile_wb_scheduler_pkg
// Brief  : Shared defaults and arbiter priority encodings for the write-back
//          scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_wb_scheduler_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREG   = 32;

    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter; index 0 is ALU, index 1 is MEM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [0:1] req,
    input  logic       advance,
    output logic [0:1] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || prio == PRIO_ALU)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Pointer always moves to the requester that lost (or did not ask).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= PRIO_ALU;
        end else if (advance) begin
            prio <= gnt[0] ? PRIO_MEM : PRIO_ALU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// Module : regfile_wb_scheduler
// Brief  : Busy scoreboard for issue hazards plus ALU/MEM write-back
//          arbitration onto a single register-file write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_ra,
    input  logic [ADDR_W-1:0] iss_rb,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              iss_wr,
    output logic              iss_stall,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    logic [0:NREG-1]   busy;
    logic [0:NREG-1]   busy_nxt;
    logic [0:1]        req;
    logic [0:1]        gnt;
    logic              grant;
    logic [ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0] grant_data;
    logic              issue_set;

    // Requests are masked by reset so no grant can be shown while held.
    assign req = {alu_valid & reset_n, mem_valid & reset_n};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (grant),
        .gnt     (gnt)
    );

    assign alu_ready  = gnt[0];
    assign mem_ready  = gnt[1];
    assign grant      = gnt[0] | gnt[1];
    assign grant_rd   = gnt[0] ? alu_rd   : mem_rd;
    assign grant_data = gnt[0] ? alu_data : mem_data;

    assign iss_stall = reset_n & iss_valid &
                       (busy[iss_ra] | busy[iss_rb] | (iss_wr & busy[iss_rd]));
    assign issue_set = iss_valid & ~iss_stall & iss_wr;

    // A same-edge set of a register overrides its write-back clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NREG; i++) begin
            if (grant && grant_rd == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (issue_set && iss_rd == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Writes to r0 are consumed silently and leave the address/data held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant && (grant_rd != '0);
            if (grant && (grant_rd != '0)) begin
                rf_waddr <= grant_rd;
                rf_wdata <= grant_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// ============================================================================
// Module : tb_regfile_wb_scheduler
// Brief  : Directed bench with a behavioural scoreboard/arbiter model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_scheduler;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              iss_valid, iss_wr, iss_stall;
    logic [ADDR_W-1:0] iss_ra, iss_rb, iss_rd;
    logic              alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_ra(iss_ra), .iss_rb(iss_rb),
        .iss_rd(iss_rd), .iss_wr(iss_wr), .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Behavioural model: set of busy registers, whose turn it is, last write.
    logic [NREG-1:0]   m_busy;
    logic              m_turn_mem;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    wire exp_alu_g = reset_n && alu_valid && (!mem_valid || !m_turn_mem);
    wire exp_mem_g = reset_n && mem_valid && (!alu_valid || m_turn_mem);
    wire exp_stall = reset_n && iss_valid &&
                     (m_busy[iss_ra] || m_busy[iss_rb] || (iss_wr && m_busy[iss_rd]));
    wire              g_any  = exp_alu_g || exp_mem_g;
    wire [ADDR_W-1:0] g_rd   = exp_alu_g ? alu_rd : mem_rd;
    wire [DATA_W-1:0] g_data = exp_alu_g ? alu_data : mem_data;

    function automatic logic [NREG-1:0] next_busy();
        logic [NREG-1:0] b;
        b = m_busy;
        if (g_any) b[g_rd] = 1'b0;
        if (iss_valid && !exp_stall && iss_wr) b[iss_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy     <= '0;
            m_turn_mem <= 1'b0;
            m_we       <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
        end else begin
            m_busy <= next_busy();
            if (g_any) m_turn_mem <= exp_alu_g;
            m_we <= g_any && (g_rd != 0);
            if (g_any && g_rd != 0) begin
                m_waddr <= g_rd;
                m_wdata <= g_data;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("mdl_stall", 64'(iss_stall), 64'(exp_stall));
        check("mdl_alu_ready", 64'(alu_ready), 64'(exp_alu_g));
        check("mdl_mem_ready", 64'(mem_ready), 64'(exp_mem_g));
        check("mdl_rf_we", 64'(rf_we), 64'(m_we));
        check("mdl_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("mdl_rf_wdata", rf_wdata, m_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_wr = 0; iss_ra = 0; iss_rb = 0; iss_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic issue(input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic wr);
        iss_valid = 1; iss_ra = ra; iss_rb = rb; iss_rd = rd; iss_wr = wr;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        alu_valid = 1; mem_valid = 1; issue(5'd1, 5'd2, 5'd3, 1'b1);
        #1;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_stall", 64'(iss_stall), 64'd0);
        idle();
        step(); step();
        reset_n = 1'b1;

        // Both requesters held: ALU, MEM, ALU, MEM from reset pointer.
        alu_valid = 1; alu_rd = 5'd10; alu_data = 64'hA;
        mem_valid = 1; mem_rd = 5'd11; mem_data = 64'hB;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("alt_alu_ready", 64'(alu_ready), 64'((k % 2) == 0));
            check("alt_mem_ready", 64'(mem_ready), 64'((k % 2) == 1));
            step();
        end
        idle();
        #2;
        check("alt_last_waddr", 64'(rf_waddr), 64'd11);
        check("alt_last_wdata", rf_wdata, 64'hB);
        step();

        // RAW on r5 resolved by ALU write-back of 0xDEAD.
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        #2 check("raw_first_issue", 64'(iss_stall), 64'd0);
        step();
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        #2;
        check("raw_stall", 64'(iss_stall), 64'd1);
        check("raw_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0;
        #2;
        check("raw_rf_we", 64'(rf_we), 64'd1);
        check("raw_rf_waddr", 64'(rf_waddr), 64'd5);
        check("raw_rf_wdata", rf_wdata, 64'hDEAD);
        check("raw_proceeds", 64'(iss_stall), 64'd0);
        step();
        idle();

        // Set and clear of r7 at the same edge: set wins.
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        alu_valid = 1; alu_rd = 5'd7; alu_data = 64'h77;
        #2;
        check("same_edge_stall", 64'(iss_stall), 64'd0);
        check("same_edge_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0;
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        #2;
        check("same_edge_busy7", 64'(iss_stall), 64'd1);
        check("same_edge_rf_waddr", 64'(rf_waddr), 64'd7);
        step();
        mem_valid = 1; mem_rd = 5'd7; mem_data = 64'h7070;
        #2 check("r7_mem_ready", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 0;
        #2 check("r7_cleared", 64'(iss_stall), 64'd0);
        step();
        idle();

        // Write-back to r0 is granted but suppressed; rd=0 never stalls.
        mem_valid = 1; mem_rd = 5'd0; mem_data = 64'h55;
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        #2;
        check("r0_mem_ready", 64'(mem_ready), 64'd1);
        check("r0_issue_stall", 64'(iss_stall), 64'd0);
        step();
        mem_valid = 0;
        #2;
        check("r0_rf_we", 64'(rf_we), 64'd0);
        check("r0_waddr_held", 64'(rf_waddr), 64'd7);
        check("r0_wdata_held", rf_wdata, 64'h7070);
        check("r0_still_free", 64'(iss_stall), 64'd0);
        step();
        idle();

        // WAW on r3 stalls until its write-back is granted.
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        step();
        #2 check("waw_stall_a", 64'(iss_stall), 64'd1);
        step();
        #2 check("waw_stall_b", 64'(iss_stall), 64'd1);
        alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h33;
        #1;
        check("waw_stall_at_grant", 64'(iss_stall), 64'd1);
        check("waw_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 0;
        #2;
        check("waw_released", 64'(iss_stall), 64'd0);
        check("waw_rf_we", 64'(rf_we), 64'd1);
        step();
        idle();

        // Reset while a write-back sits in the output register.
        alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h99;
        issue(5'd0, 5'd0, 5'd12, 1'b1);
        step();
        check("pre_rst_rf_we", 64'(rf_we), 64'd1);
        reset_n = 1'b0;
        issue(5'd3, 5'd12, 5'd0, 1'b0);
        #1;
        check("mid_rst_rf_we", 64'(rf_we), 64'd0);
        check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        check("mid_rst_wdata", rf_wdata, 64'd0);
        check("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
        check("mid_rst_stall", 64'(iss_stall), 64'd0);
        step();
        idle();
        reset_n = 1'b1;
        #2 check("post_rst_rf_we", 64'(rf_we), 64'd0);
        issue(5'd3, 5'd12, 5'd3, 1'b1);
        #1 check("post_rst_busy_clear", 64'(iss_stall), 64'd0);
        step();
        idle();
        #2 check("post_rst_no_pulse", 64'(rf_we), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
